// File: rtl/edge_event_logger_pkg.sv
// Shared types and entry-layout helpers for edge_event_logger.
// An entry is packed as {ts, fire, rise}, with rise in the least-significant bits.
package edge_event_logger_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    POS  = 2'b01,
    NEG  = 2'b10,
    BOTH = 2'b11
  } edge_mode_e;

  localparam int DEF_N_CH = 4;
  localparam int DEF_TS_W = 5;
  localparam int ENTRY_W  = DEF_TS_W + DEF_N_CH + DEF_N_CH;
  localparam int RISE_LSB = 0;
  localparam int FIRE_LSB = DEF_N_CH;
  localparam int TS_LSB   = DEF_N_CH + DEF_N_CH;

  function automatic int entry_w(input int ts_w, input int n_ch);
    return ts_w + n_ch + n_ch;
  endfunction

  function automatic int fire_lsb(input int n_ch);
    return n_ch;
  endfunction

  function automatic int ts_lsb(input int n_ch);
    return n_ch + n_ch;
  endfunction

  function automatic edge_mode_e mask_mode(input logic pos, input logic neg);
    case ({neg, pos})
      2'b01:   return POS;
      2'b10:   return NEG;
      2'b11:   return BOTH;
      default: return NONE;
    endcase
  endfunction

  function automatic logic mode_pos(input edge_mode_e m);
    case (m)
      POS, BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic mode_neg(input edge_mode_e m);
    case (m)
      NEG, BOTH: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_event_logger_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with wrap-bit pointers and async reset.
// A push into a full FIFO is accepted only when a pop retires the head in the same cycle.
module edge_event_logger_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 13,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Status flags, handshake qualification and a zeroed head while empty.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    level     = wr_ptr_r - rd_ptr_r;
    if (empty) begin
      rdata = '0;
    end else begin
      rdata = mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are irrelevant until addressed by a valid pointer.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/edge_event_logger.sv
// Edge-event recorder: samples trigger lines, qualifies edges and logs timestamped entries.
// Optional macro EDGE_EVENT_LOGGER_DROP_CNT_EN adds the saturating drop_cnt_o port.
module edge_event_logger
  import edge_event_logger_pkg::*;
#(
  parameter int              N_CH     = 4,
  parameter int              TS_W     = 5,
  parameter int              DEPTH    = 8,
  parameter logic [N_CH-1:0] POS_MASK = 4'b1111,
  parameter logic [N_CH-1:0] NEG_MASK = 4'b0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         trg_i,
  input  logic [N_CH-1:0]         en_i,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [TS_W-1:0]         evt_ts_o,
  output logic [N_CH-1:0]         evt_fire_o,
  output logic [N_CH-1:0]         evt_rise_o,
  output logic                    ovf_o,
  output logic [$clog2(DEPTH):0]  level_o
`ifdef EDGE_EVENT_LOGGER_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt_o
`endif
);

  localparam int EW    = entry_w(TS_W, N_CH);
  localparam int F_LSB = fire_lsb(N_CH);
  localparam int T_LSB = ts_lsb(N_CH);

  logic [N_CH-1:0] trg_q_r;
  logic [TS_W-1:0] ts_r;
  logic            ovf_r;
  logic [N_CH-1:0] rise_s;
  logic [N_CH-1:0] fall_s;
  logic [N_CH-1:0] fire_s;
  logic [N_CH-1:0] rise_fld_s;
  logic            push_req_s;
  logic            pop_s;
  logic            drop_s;
  logic            full_s;
  logic            empty_s;
  logic [EW-1:0]   wdata_s;
  logic [EW-1:0]   rdata_s;

  // Edge detection, per-channel qualification and push/drop decision.
  always_comb begin
    rise_s = trg_i & ~trg_q_r;
    fall_s = ~trg_i & trg_q_r;
    fire_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      fire_s[i] = en_i[i] &
                  ((rise_s[i] & mode_pos(mask_mode(POS_MASK[i], NEG_MASK[i]))) |
                   (fall_s[i] & mode_neg(mask_mode(POS_MASK[i], NEG_MASK[i]))));
    end
    rise_fld_s = rise_s & fire_s;
    push_req_s = |fire_s;
    pop_s      = ~empty_s & evt_ready_i;
    drop_s     = push_req_s & full_s & ~pop_s;
    wdata_s    = {ts_r, fire_s, rise_fld_s};
  end

  // Previous trigger sample, free-running timestamp and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trg_q_r <= '0;
      ts_r    <= '0;
      ovf_r   <= 1'b0;
    end else begin
      trg_q_r <= trg_i;
      ts_r    <= ts_r + {{(TS_W-1){1'b0}}, 1'b1};
      if (drop_s) ovf_r <= 1'b1;
    end
  end

  edge_event_logger_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req_s & ~drop_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_o)
  );

  assign evt_valid_o = ~empty_s;
  assign evt_rise_o  = rdata_s[RISE_LSB +: N_CH];
  assign evt_fire_o  = rdata_s[F_LSB +: N_CH];
  assign evt_ts_o    = rdata_s[T_LSB +: TS_W];
  assign ovf_o       = ovf_r;

`ifdef EDGE_EVENT_LOGGER_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // One count per dropping cycle, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_edge_event_logger.sv
// Scoreboard bench for edge_event_logger (channel 0 both-edge, channels 1..3 rising only).
module tb_edge_event_logger;

  localparam int N_CH = 4;
  localparam int TS_W = 5;
  localparam int DEPTH = 8;
  localparam logic [3:0] POS = 4'b1111;
  localparam logic [3:0] NEG = 4'b0001;

  typedef logic [12:0] ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] trg_i = 4'b0000;
  logic [3:0] en_i = 4'b1111;
  logic       evt_ready_i = 1'b0;
  logic       evt_valid_o;
  logic [4:0] evt_ts_o;
  logic [3:0] evt_fire_o;
  logic [3:0] evt_rise_o;
  logic       ovf_o;
  logic [3:0] level_o;
`ifdef EDGE_EVENT_LOGGER_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
`endif

  always #5 clk = ~clk;

  edge_event_logger #(
    .N_CH(N_CH), .TS_W(TS_W), .DEPTH(DEPTH), .POS_MASK(POS), .NEG_MASK(NEG)
  ) dut (
    .clk(clk), .rst(rst), .trg_i(trg_i), .en_i(en_i),
    .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_ts_o(evt_ts_o), .evt_fire_o(evt_fire_o), .evt_rise_o(evt_rise_o),
    .ovf_o(ovf_o), .level_o(level_o)
`ifdef EDGE_EVENT_LOGGER_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  ent_t exp_q[$];
  ent_t obs_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] m_prev;
  logic [4:0] m_ts;
  int m_lvl;

  task automatic model_clear();
    m_prev = 4'b0000;
    m_ts = 5'd0;
    m_lvl = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // One cycle of stimulus: records popped DUT entries, predicts accepted entries.
  task automatic drive(input logic [3:0] t, input logic [3:0] e, input bit r);
    logic [3:0] rise_v, fall_v, fire_v;
    bit pop_v;
    trg_i = t;
    en_i = e;
    evt_ready_i = r;
    #1;
    if (r && evt_valid_o) obs_q.push_back({evt_ts_o, evt_fire_o, evt_rise_o});
    rise_v = t & ~m_prev;
    fall_v = ~t & m_prev;
    fire_v = e & ((rise_v & POS) | (fall_v & NEG));
    pop_v = r && (m_lvl > 0);
    if ((|fire_v) && ((m_lvl < DEPTH) || pop_v)) begin
      exp_q.push_back({m_ts, fire_v, rise_v & fire_v});
      m_lvl++;
    end
    if (pop_v) m_lvl--;
    @(posedge clk);
    m_prev = t;
    m_ts = m_ts + 5'd1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({evt_valid_o, level_o, ovf_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_status got valid=%b level=%0d ovf=%b want 0/0/0", evt_valid_o, level_o, ovf_o);
    end
    n_checks++;
    if ({evt_ts_o, evt_fire_o, evt_rise_o} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_head got ts=%0d fire=%b rise=%b want zeros", evt_ts_o, evt_fire_o, evt_rise_o);
    end
`ifdef EDGE_EVENT_LOGGER_DROP_CNT_EN
    n_checks++;
    if (drop_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt_o);
    end
`endif
    do_reset();
  endtask

  task automatic test_single_edge();
    do_reset();
    repeat (3) drive(4'b0000, 4'b1111, 1'b1);
    drive(4'b0010, 4'b1111, 1'b1);
    n_checks++;
    if ({evt_valid_o, level_o, evt_ts_o, evt_fire_o, evt_rise_o} !== {1'b1, 4'd1, 5'd3, 4'b0010, 4'b0010}) begin
      n_fail++;
      $display("FAIL single_head got v=%b lvl=%0d ts=%0d f=%b r=%b want 1/1/3/0010/0010",
               evt_valid_o, level_o, evt_ts_o, evt_fire_o, evt_rise_o);
    end
    drive(4'b0000, 4'b1111, 1'b1);
    n_checks++;
    if ({evt_valid_o, level_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_fall_no_entry got v=%b lvl=%0d want 0/0", evt_valid_o, level_o);
    end
    repeat (2) drive(4'b0000, 4'b1111, 1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL single_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ent_t o = obs_q.pop_front();
      ent_t x = exp_q.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL single_entry got %h want %h", o, x); end
    end
  endtask

  task automatic test_both_edge();
    do_reset();
    repeat (5) drive(4'b0000, 4'b0001, 1'b0);
    drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0001, 1'b0);
    drive(4'b0001, 4'b0001, 1'b0);
    n_checks++;
    if ({level_o, evt_ts_o, evt_rise_o} !== {4'd3, 5'd5, 4'b0001}) begin
      n_fail++;
      $display("FAIL both_level_head got lvl=%0d ts=%0d r=%b want 3/5/0001", level_o, evt_ts_o, evt_rise_o);
    end
    repeat (4) drive(4'b0001, 4'b0001, 1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 3) begin
      n_fail++;
      $display("FAIL both_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ent_t o = obs_q.pop_front();
      ent_t x = exp_q.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL both_entry got %h want %h", o, x); end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(4'b0000, 4'b1111, 1'b0);
    drive(4'b1010, 4'b0010, 1'b0);
    n_checks++;
    if ({level_o, evt_fire_o, evt_rise_o} !== {4'd1, 4'b0010, 4'b0010}) begin
      n_fail++;
      $display("FAIL same_en_mask got lvl=%0d f=%b r=%b want 1/0010/0010", level_o, evt_fire_o, evt_rise_o);
    end
    drive(4'b0000, 4'b0010, 1'b1);
    drive(4'b1010, 4'b0000, 1'b1);
    n_checks++;
    if ({evt_valid_o, level_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL same_disabled got v=%b lvl=%0d want 0/0", evt_valid_o, level_o);
    end
    drive(4'b0000, 4'b1111, 1'b0);
    drive(4'b0111, 4'b1111, 1'b0);
    drive(4'b0110, 4'b1111, 1'b0);
    n_checks++;
    if (level_o !== 4'd2) begin
      n_fail++;
      $display("FAIL same_merge_level got %0d want 2", level_o);
    end
    repeat (3) drive(4'b0110, 4'b1111, 1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 3) begin
      n_fail++;
      $display("FAIL same_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ent_t o = obs_q.pop_front();
      ent_t x = exp_q.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL same_entry got %h want %h", o, x); end
    end
  endtask

  task automatic test_full_drop();
    logic [3:0] t = 4'b0000;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      t = t ^ 4'b0001;
      drive(t, 4'b0001, 1'b0);
    end
    n_checks++;
    if ({evt_valid_o, level_o, ovf_o} !== {1'b1, 4'd8, 1'b1}) begin
      n_fail++;
      $display("FAIL full_drop_status got v=%b lvl=%0d ovf=%b want 1/8/1", evt_valid_o, level_o, ovf_o);
    end
`ifdef EDGE_EVENT_LOGGER_DROP_CNT_EN
    n_checks++;
    if (drop_cnt_o !== 8'd1) begin
      n_fail++;
      $display("FAIL full_drop_cnt got %0d want 1", drop_cnt_o);
    end
`endif
    repeat (9) drive(t, 4'b0001, 1'b1);
    n_checks++;
    if ({level_o, ovf_o} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL full_drain_status got lvl=%0d ovf=%b want 0/1", level_o, ovf_o);
    end
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 8) begin
      n_fail++;
      $display("FAIL full_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ent_t o = obs_q.pop_front();
      ent_t x = exp_q.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL full_entry got %h want %h", o, x); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] t = 4'b0000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      t = t ^ 4'b0001;
      drive(t, 4'b0001, 1'b0);
    end
    t = t ^ 4'b0001;
    drive(t, 4'b0001, 1'b1);
    n_checks++;
    if ({level_o, ovf_o} !== {4'd8, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_full_pushpop got lvl=%0d ovf=%b want 8/0", level_o, ovf_o);
    end
    repeat (9) drive(t, 4'b0001, 1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 9) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ent_t o = obs_q.pop_front();
      ent_t x = exp_q.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL b2b_entry got %h want %h", o, x); end
    end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    repeat (31) drive(4'b0000, 4'b0001, 1'b1);
    drive(4'b0001, 4'b0001, 1'b0);
    drive(4'b0000, 4'b0001, 1'b0);
    n_checks++;
    if ({level_o, evt_ts_o} !== {4'd2, 5'd31}) begin
      n_fail++;
      $display("FAIL wrap_first got lvl=%0d ts=%0d want 2/31", level_o, evt_ts_o);
    end
    drive(4'b0000, 4'b0001, 1'b1);
    n_checks++;
    if ({evt_valid_o, evt_ts_o, evt_rise_o} !== {1'b1, 5'd0, 4'b0000}) begin
      n_fail++;
      $display("FAIL wrap_second got v=%b ts=%0d r=%b want 1/0/0000", evt_valid_o, evt_ts_o, evt_rise_o);
    end
    repeat (2) drive(4'b0000, 4'b0001, 1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 2) begin
      n_fail++;
      $display("FAIL wrap_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ent_t o = obs_q.pop_front();
      ent_t x = exp_q.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL wrap_entry got %h want %h", o, x); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] t = 4'b0000;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      t = t ^ 4'b0001;
      drive(t, 4'b0001, 1'b0);
    end
    trg_i = 4'b0001;
    en_i = 4'b1111;
    evt_ready_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({evt_valid_o, level_o, ovf_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL midrst_immediate got v=%b lvl=%0d ovf=%b want 0/0/0", evt_valid_o, level_o, ovf_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    drive(4'b0001, 4'b1111, 1'b0);
    n_checks++;
    if ({level_o, evt_ts_o, evt_fire_o, evt_rise_o} !== {4'd1, 5'd0, 4'b0001, 4'b0001}) begin
      n_fail++;
      $display("FAIL midrst_first_edge got lvl=%0d ts=%0d f=%b r=%b want 1/0/0001/0001",
               level_o, evt_ts_o, evt_fire_o, evt_rise_o);
    end
    repeat (2) drive(4'b0001, 4'b1111, 1'b1);
    n_checks++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 1) begin
      n_fail++;
      $display("FAIL midrst_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      ent_t o = obs_q.pop_front();
      ent_t x = exp_q.pop_front();
      n_checks++;
      if (o !== x) begin n_fail++; $display("FAIL midrst_entry got %h want %h", o, x); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_edge();
    test_both_edge();
    test_same_cycle();
    test_full_drop();
    test_back_to_back();
    test_ts_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_logger.md
Name: edge_event_logger

Overview:
Synthesizable edge-event recorder that consumes trigger/enable patterns from the stimulus stage. Each cycle it samples N trigger lines on the global clock and detects rising and falling edges against the previous sample. Edges are qualified by per-channel edge-mode masks and per-channel enables. Qualified edges are logged as timestamped entries into a FIFO that a downstream checker drains through a valid/ready handshake. This gives a clk2fflogic-friendly, formally checkable replacement for multi-edge always-block effects.

Parameters:
N_CH, 4, number of trigger channels
TS_W, 5, timestamp counter width; free-running, wraps
DEPTH, 8, FIFO entries; power of two, >= 2
POS_MASK, 4'b1111 (N_CH bits), channel i reacts to rising edges when bit i = 1
NEG_MASK, 4'b0000 (N_CH bits), channel i reacts to falling edges when bit i = 1

Ports:
clk  in  1  single clock; all state on posedge
rst  in  1  asynchronous, active-high reset
trg_i  in  N_CH  trigger levels, sampled each clk
en_i  in  N_CH  per-channel enable, sampled in the same cycle as trg_i
evt_valid_o  out  1  head entry available
evt_ready_i  in  1  consumer accepts head entry
evt_ts_o  out  TS_W  timestamp of head entry
evt_fire_o  out  N_CH  channels that fired in head entry
evt_rise_o  out  N_CH  edge direction per channel (1 = rising); meaningful only where fire = 1
ovf_o  out  1  sticky: at least one entry dropped
level_o  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, released synchronously by the flops):
  - trg_q = 0, ts = 0, FIFO empty, ovf_o = 0, level_o = 0, evt_valid_o = 0.
  - evt_ts_o, evt_fire_o and evt_rise_o read 0 while empty.
- Edge detection per cycle:
  - rise = trg_i & ~trg_q; fall = ~trg_i & trg_q; then trg_q <= trg_i.
  - Because trg_q resets to 0, a line already high at the first sampled cycle produces a rising edge.
- Qualification:
  - fire[i] = en_i[i] & ((rise[i] & POS_MASK[i]) | (fall[i] & NEG_MASK[i])).
  - rise field = rise[i] & fire[i].
- Push:
  - An entry {ts, fire, rise} is pushed when |fire.
  - At most one entry per cycle; simultaneous channel edges merge into one entry.
  - A both-edge channel (POS & NEG set) logs every toggle.
- Latency: an edge detected in cycle t is written at the end of t and can appear as evt_valid_o at t+1 (no bypass).
- Timestamp: ts increments every cycle and wraps from 2^TS_W-1 to 0. The entry carries the ts value of the detection cycle.
- Pop: the head entry is retired when evt_valid_o & evt_ready_i. Outputs are stable while valid & ~ready.
- Full:
  - Push with pop in the same cycle: both happen, level unchanged.
  - Push without pop: the new entry is dropped and ovf_o is set to 1 (sticky until rst).
- Empty: pop is ignored (valid = 0). Push into empty gives level 1 next cycle.
- Reset mid-operation: all entries are discarded immediately and ovf_o clears. An edge present on the first cycle after release follows the trg_q = 0 rule.
- Pointers: read/write pointers are clog2(DEPTH)+1 bits with a wrap bit. full = MSBs differ and the rest are equal.

Optional Feature:
- Macro: EDGE_EVENT_LOGGER_DROP_CNT_EN.
- When defined:
  - Adds port drop_cnt_o, out, 8 bits: saturating count of dropped entries.
  - Resets to 0; holds at 255 once reached.
  - Increments by 1 per dropped cycle, regardless of how many channels fired in it.
- When undefined: the port and counter are absent; only sticky ovf_o indicates loss.

Decomposition:
- Package edge_event_logger_pkg holds:
  - typedef edge_mode_e: NONE, POS, NEG, BOTH, with helpers mapping a mode to POS/NEG mask bits.
  - Parameterized entry layout constants: ENTRY_W = TS_W + 2*N_CH, plus field offsets.
- Sub-module edge_event_logger_fifo: a generic DEPTH x ENTRY_W synchronous FIFO with push/pop, full/empty, level and async reset. The top holds the edge detection, qualification, timestamp and overflow logic.

Test Plan:
- Setup: N_CH=4, POS=1111, NEG=0000, en=1111, ready=1. trg 0000->0001 at ts=3 -> one entry at ts=4 cycle: ts=3, fire=0001, rise=0001. trg back to 0000 -> no entry.
- Setup: POS=NEG=0001, en=0001. trg[0] toggles at ts=5,6,7 -> three entries: ts 5/6/7, rise 1/0/1.
- Same cycle: trg 0000->1010 with en=0010 -> single entry fire=0010. With en=0000 -> no entry, level stays 0.
- Full and drop (DEPTH=8, ready=0): 9 qualified edges -> level_o=8, ninth dropped, ovf_o=1. With DROP_CNT_EN: drop_cnt_o=1. Then ready=1 -> 8 entries drain in order, ovf_o still 1.
- Full with concurrent push/pop: level=8, push and pop in the same cycle -> level stays 8, no overflow. Timestamp wrap: edge at ts=31, then edge at ts=0 -> entries carry 31 and 0.
- Reset mid-stream: level=5, assert rst for 1 cycle -> valid=0, level=0, ovf=0 immediately. Release with trg=0001 held -> one rising entry at ts=0.
